// File: rtl/serial_cpu_pkg.sv
// Shared types and instruction field layout for the bit-serial CPU control path.
// Imported by the sequencer and its bit counter.
package serial_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OPC_NOP = 4'hF;
  localparam logic [3:0] OPC_CMP = 4'hE;

  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int RS1_MSB = 2;
  localparam int RS1_LSB = 0;

  // NOP and CMP only update flags, so they skip the parallel write-back.
  function automatic logic opc_writes_back(input logic [3:0] opcode);
    return (opcode != OPC_NOP) && (opcode != OPC_CMP);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo bit counter for the serial shift sequence; flags bit 0 and the
// terminal bit only on cycles where the counter actually advances.
module serial_bit_counter #(
  parameter int unsigned MODULUS = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(MODULUS)-1:0] count,
  output logic                       first,
  output logic                       last
);

  localparam int CW = $clog2(MODULUS);

  // MODULUS is a power of two, so the natural roll-over is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign first = en && (count == '0);
  assign last  = en && (count == CW'(MODULUS - 1));

endmodule

// File: rtl/serial_exec_ctrl.sv
// Sequencer for the bit-serial register file: accepts one instruction, then
// issues REG_WIDTH shift pulses, an optional write-back strobe and a done pulse.
module serial_exec_ctrl
  import serial_cpu_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = 8,
  parameter int unsigned INSTR_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         instr_valid,
  input  logic [INSTR_WIDTH-1:0]       instr_in,
  output logic                         instr_ready,
  input  logic                         hold,
  output logic [INSTR_WIDTH-1:0]       instr_q,
  output logic                         is_rtype,
  output logic                         reg_shift_en,
  output logic                         reg_store_en,
  output logic [$clog2(REG_WIDTH)-1:0] bit_idx,
  output logic                         first_bit,
  output logic                         last_bit,
  output logic                         busy,
  output logic                         done,
  output state_t                       fsm_state
);

  generate
    if (REG_WIDTH < 2 || (REG_WIDTH & (REG_WIDTH - 1)) != 0) begin : g_bad_width
      $error("serial_exec_ctrl: REG_WIDTH must be a power of two >= 2");
    end
  endgenerate

  // Handshake: a transfer happens on a clk edge where instr_valid && instr_ready;
  // the requester keeps instr_valid and instr_in stable until then.

  state_t     state;
  logic [3:0] opcode;
  logic       wb;
  logic       accept;
  logic       shift_active;

  assign opcode       = instr_q[OPC_MSB:OPC_LSB];
  assign is_rtype     = ~opcode[3];
  assign wb           = opc_writes_back(opcode);
  assign accept       = instr_valid && instr_ready;
  assign shift_active = (state == ST_SHIFT) && !hold;

  serial_bit_counter #(
    .MODULUS (REG_WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (accept),
    .en    (shift_active),
    .count (bit_idx),
    .first (first_bit),
    .last  (last_bit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      instr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr_in;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // last_bit is already gated by hold, so a stalled cycle never exits.
          if (last_bit) begin
            state <= wb ? ST_STORE : ST_DONE;
          end
        end
        ST_STORE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready  = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign reg_shift_en = shift_active;
  assign reg_store_en = (state == ST_STORE);
  assign done         = (state == ST_DONE);
  assign fsm_state    = state;

endmodule

// File: tb/tb_serial_exec_ctrl.sv
// Directed bench for serial_exec_ctrl: cycle-accurate timing of shift, store,
// done and ready for several instructions, hold stalls, back-to-back and reset.
module tb_serial_exec_ctrl;
  import serial_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr_in = 12'h000;
  logic        hold = 1'b0;
  logic        instr_ready;
  logic [11:0] instr_q;
  logic        is_rtype;
  logic        reg_shift_en;
  logic        reg_store_en;
  logic [2:0]  bit_idx;
  logic        first_bit;
  logic        last_bit;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;

  serial_exec_ctrl #(
    .REG_WIDTH   (8),
    .INSTR_WIDTH (12)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .instr_valid  (instr_valid),
    .instr_in     (instr_in),
    .instr_ready  (instr_ready),
    .hold         (hold),
    .instr_q      (instr_q),
    .is_rtype     (is_rtype),
    .reg_shift_en (reg_shift_en),
    .reg_store_en (reg_store_en),
    .bit_idx      (bit_idx),
    .first_bit    (first_bit),
    .last_bit     (last_bit),
    .busy         (busy),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Offers instr in the current cycle (cycle 0) and observes cycles 1.. until
  // ready returns; returns in that ready cycle. Event cycles are checked against
  // hand-computed constants.
  task automatic run_instr(input string name, input logic [11:0] instr,
                           input logic keep_valid, input logic [11:0] next_instr,
                           input int hs, input int he, input logic exp_rtype,
                           input int e_last, input int e_store, input int e_done,
                           input int e_ready);
    int first_c = -1;
    int last_c  = -1;
    int store_c = -1;
    int done_c  = -1;
    int ready_c = -1;
    int nshift  = 0;
    int overlap = 0;
    int qbad    = 0;
    int rdybad  = 0;
    int holdbad = 0;
    instr_valid = 1'b1;
    instr_in    = instr;
    settle();
    chk({name, "_ready_c0"}, instr_ready, 1);
    for (int c = 1; c <= 30 && ready_c < 0; c++) begin
      step();
      hold = (c >= hs) && (c <= he);
      if (keep_valid) instr_in = next_instr;
      else instr_valid = 1'b0;
      settle();
      if (c == 1) chk({name, "_is_rtype"}, is_rtype, exp_rtype);
      if (reg_shift_en) nshift++;
      if (first_bit && first_c < 0) first_c = c;
      if (last_bit && last_c < 0) last_c = c;
      if (reg_store_en && store_c < 0) store_c = c;
      if (done && done_c < 0) done_c = c;
      if (reg_shift_en && reg_store_en) overlap++;
      if (hold && (reg_shift_en || first_bit || last_bit || bit_idx !== 3'd2)) holdbad++;
      if (busy === instr_ready) rdybad++;
      if (instr_ready) ready_c = c;
      else if (instr_q !== instr) qbad++;
    end
    hold = 1'b0;
    chk({name, "_first_cyc"}, first_c, 1);
    chk({name, "_last_cyc"},  last_c,  e_last);
    chk({name, "_store_cyc"}, store_c, e_store);
    chk({name, "_done_cyc"},  done_c,  e_done);
    chk({name, "_ready_cyc"}, ready_c, e_ready);
    chk({name, "_nshift"},    nshift,  8);
    chk({name, "_overlap"},   overlap, 0);
    chk({name, "_instr_q"},   qbad,    0);
    chk({name, "_busy_rdy"},  rdybad,  0);
    chk({name, "_hold"},      holdbad, 0);
  endtask

  initial begin
    int stray;

    // reset
    rstn = 1'b0;
    step();
    step();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_instr_q", instr_q, 0);
    chk("rst_done", done, 0);
    chk("rst_shift", reg_shift_en, 0);
    chk("rst_store", reg_store_en, 0);
    rstn = 1'b1;
    step();
    step();

    // R-type with write-back
    run_instr("rtype", 12'h012, 1'b0, 12'h000, -1, -1, 1'b1, 8, 9, 10, 11);
    // I-type with write-back
    run_instr("itype", 12'h812, 1'b0, 12'h000, -1, -1, 1'b0, 8, 9, 10, 11);
    // NOP and CMP skip the store
    run_instr("nop", 12'hF00, 1'b0, 12'h000, -1, -1, 1'b0, 8, -1, 9, 10);
    run_instr("cmp", 12'hE21, 1'b0, 12'h000, -1, -1, 1'b0, 8, -1, 9, 10);
    // stall at bit 2 for cycles 3..5
    run_instr("hold", 12'h012, 1'b0, 12'h000, 3, 5, 1'b1, 11, 12, 13, 14);
    // back-to-back with valid held high throughout
    run_instr("b2b_a", 12'h012, 1'b1, 12'h023, -1, -1, 1'b1, 8, 9, 10, 11);
    run_instr("b2b_b", 12'h023, 1'b0, 12'h000, -1, -1, 1'b1, 8, 9, 10, 11);

    // reset during cycle 5 of the shift sequence
    instr_valid = 1'b1;
    instr_in = 12'h812;
    for (int c = 1; c <= 5; c++) begin
      step();
      instr_valid = 1'b0;
    end
    settle();
    chk("rstmid_shift_c5", reg_shift_en, 1);
    chk("rstmid_bit_c5", bit_idx, 4);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    settle();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", instr_ready, 1);
    chk("rstmid_bit_idx", bit_idx, 0);
    chk("rstmid_instr_q", instr_q, 0);
    chk("rstmid_shift", reg_shift_en, 0);
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      if (reg_shift_en || reg_store_en || done || busy) stray++;
      step();
    end
    chk("rstmid_no_strobes", stray, 0);

    // controller usable again after the aborted instruction
    run_instr("post_rst", 12'h134, 1'b0, 12'h000, -1, -1, 1'b1, 8, 9, 10, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_exec_ctrl.md
Name: serial_exec_ctrl

Overview:
- Sequencer for the bit-serial register file and datapath.
- Accepts one 12-bit instruction through a valid/ready handshake and latches it.
- Drives exactly REG_WIDTH shift pulses (LSB first), then one parallel write-back strobe, then a one-cycle done pulse.
- Sits between instruction fetch and the register file; it is the only source of reg_shift_en and reg_store_en.

Parameters:
- REG_WIDTH, 8, bits per register; number of shift cycles per instruction.
- INSTR_WIDTH, 12, instruction width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset; sampled on the rising clk edge
- instr_valid  in  1  instruction offered
- instr_in  in  12  offered instruction
- instr_ready  out  1  controller can accept
- hold  in  1  datapath stall; freezes the shift sequence
- instr_q  out  12  latched instruction, to regfile instr
- is_rtype  out  1  decoded R-type flag, to regfile
- reg_shift_en  out  1  one register bit shift this cycle
- reg_store_en  out  1  parallel store from accumulator
- bit_idx  out  $clog2(REG_WIDTH)  index of the bit currently on rs1_bit/rs2_bit
- first_bit  out  1  high during the shift of bit 0 (ALU carry init)
- last_bit  out  1  high during the shift of bit REG_WIDTH-1 (ALU flag capture)
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, instr_q=0, bit_idx=0, done=0. All strobes are 0. instr_ready=1 after reset. Reset mid-sequence aborts immediately with no further shift or store pulses.
- Decode, from instr_q:
  - opcode = instr_q[11:8]
  - is_rtype = (opcode[3]==0)
  - wb = (opcode != OPC_NOP) and (opcode != OPC_CMP)
- States: IDLE, SHIFT, STORE, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch instr_in into instr_q, set bit_idx=0, go to SHIFT.
  - Otherwise instr_q holds.
- SHIFT:
  - reg_shift_en = !hold.
  - bit_idx increments on every unheld cycle.
  - first_bit = (bit_idx==0)&&!hold; last_bit = (bit_idx==REG_WIDTH-1)&&!hold.
  - When the unheld cycle with bit_idx==REG_WIDTH-1 occurs: bit_idx wraps to 0; next state is STORE if wb, else DONE.
  - hold=1: no state or counter change; all strobes low.
- STORE: reg_store_en=1 for exactly one cycle; hold is ignored; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- instr_ready=0 in SHIFT, STORE and DONE. Back-to-back instructions therefore start every REG_WIDTH+3 cycles with write-back (REG_WIDTH+2 without).
- Latency with no hold and wb=1, handshake at cycle 0:
  - reg_shift_en high at cycles 1..REG_WIDTH
  - reg_store_en high at cycle REG_WIDTH+1
  - done high at cycle REG_WIDTH+2
  - instr_ready high again at cycle REG_WIDTH+3
- Invariants:
  - reg_shift_en and reg_store_en are never high together.
  - Shift pulses per instruction are exactly REG_WIDTH, so the regfile bit index ends at 0.
  - instr_q is stable from the handshake cycle through DONE.
- bit_idx is a modulo-REG_WIDTH counter. REG_WIDTH must be a power of two, checked by an elaboration-time check.
- instr_valid while busy is ignored. The requester must hold it until ready.

Decomposition:
- Package serial_cpu_pkg:
  - state enum (IDLE/SHIFT/STORE/DONE)
  - OPC_NOP=4'hF, OPC_CMP=4'hE
  - opcode field positions [11:8], rs2 [6:4], rs1 [2:0]
- One sub-module, serial_bit_counter: modulo counter with enable, clear, and a terminal-count flag. It provides bit_idx, first_bit and last_bit.
- FSM and decode stay in the top module.

Test Plan:
- Reset, then instr_in=12'h012 (opcode 0) with valid at cycle 0 -> shift_en cycles 1-8; first_bit at 1; last_bit at 8; store_en at 9; done at 10; ready at 11; is_rtype=1.
- instr_in=12'h812 (opcode 8) -> is_rtype=0; same timing; store_en at cycle 9.
- instr_in=12'hF00 (NOP) -> 8 shifts; no store_en; done at cycle 9; ready at 10.
- hold=1 during cycles 3-5 of the shift -> shift_en low for 3 cycles; bit_idx frozen at 2; total shifts still 8; store at cycle 12; done at 13.
- Back-to-back valid held high with 12'h012 then 12'h023 -> second handshake at cycle 11; instr_q changes only then; no overlap of shift and store.
- rstn=0 at cycle 5 of the shift -> next cycle IDLE, bit_idx=0, no store_en, no done; ready=1 after release.
